// File: rtl/digit_scan_sequencer.sv
// Frame-level controller for the 3x3 digit feature scanner: steps the scan window one slot
// per frame, decodes captured codes against a loadable table, debounces, and publishes digits.
module digit_scan_sequencer #(
  parameter int NUM_SLOTS  = 4,
  parameter int BASE_LEFT  = 70,
  parameter int BASE_UP    = 80,
  parameter int SLOT_PITCH = 80,
  parameter int WIN_W      = 70,
  parameter int WIN_H      = 110,
  parameter int STABLE_N   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_vs,
  input  logic                   feat_valid,
  input  logic [8:0]             feat_code,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_idx,
  input  logic [8:0]             cfg_code,
  output logic [11:0]            win_left,
  output logic [11:0]            win_right,
  output logic [11:0]            win_up,
  output logic [11:0]            win_down,
  output logic [2:0]             cur_slot,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NUM_SLOTS-1:0] out_digits,
  output logic                   overrun
);

  typedef enum logic [2:0] {S_SYNC, S_ARM, S_SCAN, S_EVAL, S_NEXT} state_t;

  localparam logic [2:0] LAST_SLOT  = 3'(NUM_SLOTS - 1);
  localparam logic [2:0] STABLE_CNT = 3'(STABLE_N);

  function automatic logic [11:0] left_of(input logic [2:0] slot);
    return 12'(BASE_LEFT + int'(slot) * SLOT_PITCH);
  endfunction

  state_t      state;
  logic        vs_d;
  logic        got;
  logic [8:0]  cap;
  logic [8:0]  tab [10];
  logic [9:0]  tv;
  logic [3:0]  cand   [NUM_SLOTS];
  logic [2:0]  cnt    [NUM_SLOTS];
  logic [3:0]  stable [NUM_SLOTS];

  logic        vs_rise, vs_fall;
  logic [3:0]  dec_digit;
  logic [3:0]  sel_cand;
  logic [2:0]  sel_cnt;
  logic [2:0]  new_cnt;
  logic [2:0]  nxt_slot;

  assign vs_rise  = i_vs & ~vs_d;
  assign vs_fall  = ~i_vs & vs_d;
  assign nxt_slot = (cur_slot == LAST_SLOT) ? 3'd0 : cur_slot + 3'd1;

  // Descending scan so the lowest matching entry is the one that sticks.
  always_comb begin
    dec_digit = 4'hF;
    if (got) begin
      for (int i = 9; i >= 0; i--) begin
        if (tv[i] && tab[i] == cap) dec_digit = 4'(i);
      end
    end
  end

  always_comb begin
    sel_cand = 4'hF;
    sel_cnt  = 3'd0;
    new_cnt  = 3'd1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (cur_slot == 3'(k)) begin
        sel_cand = cand[k];
        sel_cnt  = cnt[k];
      end
    end
    if (dec_digit == sel_cand)
      new_cnt = (sel_cnt >= STABLE_CNT) ? STABLE_CNT : sel_cnt + 3'd1;
  end

  // NOTE: tab has no reset; tv gates every entry, so only the valid bits need clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= '0;
    end else if (cfg_we && cfg_idx <= 4'd9) begin
      tab[cfg_idx] <= cfg_code;
      tv[cfg_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SYNC;
      vs_d       <= 1'b0;
      got        <= 1'b0;
      cap        <= '0;
      cur_slot   <= 3'd0;
      win_left   <= left_of(3'd0);
      win_right  <= left_of(3'd0) + 12'(WIN_W);
      win_up     <= 12'(BASE_UP);
      win_down   <= 12'(BASE_UP + WIN_H);
      out_valid  <= 1'b0;
      out_digits <= '1;
      overrun    <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        cand[k]   <= 4'hF;
        cnt[k]    <= 3'd0;
        stable[k] <= 4'hF;
      end
    end else begin
      // NOTE: non-blocking updates let the sweep load below override this clear in the same cycle.
      vs_d    <= i_vs;
      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        S_SYNC: if (vs_fall) state <= S_ARM;
        S_ARM: begin
          if (vs_rise) begin
            state <= S_SCAN;
            got   <= 1'b0;
            cap   <= '0;
          end
        end
        S_SCAN: begin
          if (feat_valid && !got) begin
            got <= 1'b1;
            cap <= feat_code;
          end
          if (vs_fall) state <= S_EVAL;
        end
        S_EVAL: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (cur_slot == 3'(k)) begin
              cand[k] <= dec_digit;
              cnt[k]  <= new_cnt;
              if (new_cnt == STABLE_CNT) stable[k] <= dec_digit;
            end
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          cur_slot  <= nxt_slot;
          win_left  <= left_of(nxt_slot);
          win_right <= left_of(nxt_slot) + 12'(WIN_W);
          win_up    <= 12'(BASE_UP);
          win_down  <= 12'(BASE_UP + WIN_H);
          if (cur_slot == LAST_SLOT) begin
            for (int k = 0; k < NUM_SLOTS; k++) out_digits[4*k +: 4] <= stable[k];
            out_valid <= 1'b1;
            overrun   <= out_valid & ~out_ready;
          end
          state <= S_ARM;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule
